// File: rtl/pipe_adder.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_adder
//  Function : Slice-pipelined adder/subtractor with valid/ready handshake.
//             One SLICE-bit chunk is added per stage; carry ripples between
//             stages through registers.
//  Revision : 1.0
// ============================================================================
module pipe_adder #(
   parameter int WIDTH = 16,
   parameter int SLICE = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int STAGES = WIDTH / SLICE;
   localparam int LAST   = STAGES - 1;

   logic [WIDTH-1:0] a_q     [STAGES];
   logic [WIDTH-1:0] a_d     [STAGES];
   logic [WIDTH-1:0] b_q     [STAGES];
   logic [WIDTH-1:0] b_d     [STAGES];
   logic [WIDTH-1:0] sum_q   [STAGES];
   logic [WIDTH-1:0] sum_d   [STAGES];
   logic             carry_q [STAGES];
   logic             carry_d [STAGES];
   logic             valid_q [STAGES];
   logic             valid_d [STAGES];
   logic             ovf_q;
   logic             ovf_d;

   logic [WIDTH-1:0] a_in      [STAGES];
   logic [WIDTH-1:0] b_in      [STAGES];
   logic [WIDTH-1:0] sum_in    [STAGES];
   logic             carry_in  [STAGES];
   logic             valid_in  [STAGES];
   logic [SLICE:0]   slice_res [STAGES];
   logic             stall;

   always_comb begin
      stall = valid_q[LAST] && !out_ready;

      // Subtraction folds into addition: invert b and turn borrow-in into carry-in.
      a_in[0]     = a;
      b_in[0]     = sub ? ~b : b;
      carry_in[0] = cin ^ sub;
      valid_in[0] = in_valid && !stall;
      sum_in[0]   = '0;
      for (int k = 1; k < STAGES; k++) begin
         a_in[k]     = a_q[k-1];
         b_in[k]     = b_q[k-1];
         carry_in[k] = carry_q[k-1];
         valid_in[k] = valid_q[k-1];
         sum_in[k]   = sum_q[k-1];
      end

      for (int k = 0; k < STAGES; k++) begin
         slice_res[k] = {1'b0, a_in[k][k*SLICE +: SLICE]}
                      + {1'b0, b_in[k][k*SLICE +: SLICE]}
                      + {{SLICE{1'b0}}, carry_in[k]};
         sum_d[k]                   = sum_in[k];
         sum_d[k][k*SLICE +: SLICE] = slice_res[k][SLICE-1:0];
         a_d[k]     = a_in[k];
         b_d[k]     = b_in[k];
         carry_d[k] = slice_res[k][SLICE];
         valid_d[k] = valid_in[k];
      end

      ovf_d = (a_in[LAST][WIDTH-1] == b_in[LAST][WIDTH-1])
           && (slice_res[LAST][SLICE-1] != a_in[LAST][WIDTH-1]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < STAGES; k++) begin
            a_q[k]     <= '0;
            b_q[k]     <= '0;
            sum_q[k]   <= '0;
            carry_q[k] <= 1'b0;
            valid_q[k] <= 1'b0;
         end
         ovf_q <= 1'b0;
      end else if (!stall) begin
         // Empty slots advance too, so bubbles are never squeezed out.
         for (int k = 0; k < STAGES; k++) begin
            a_q[k]     <= a_d[k];
            b_q[k]     <= b_d[k];
            sum_q[k]   <= sum_d[k];
            carry_q[k] <= carry_d[k];
            valid_q[k] <= valid_d[k];
         end
         ovf_q <= ovf_d;
      end
   end

   assign in_ready  = !stall;
   assign out_valid = valid_q[LAST];
   assign sum       = sum_q[LAST];
   assign cout      = carry_q[LAST];
   assign ovf       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_adder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_adder
//  Function : Directed and backpressure bench for pipe_adder at 16/4, 4/4
//             and 32/8 configurations, one configuration active at a time.
//  Revision : 1.0
// ============================================================================
module tb_pipe_adder;

   typedef struct packed {
      int          w;
      logic [31:0] a;
      logic [31:0] b;
      logic        cin;
      logic        sub;
      logic [31:0] s;
      logic        co;
      logic        ov;
   } vec_t;

   typedef struct {
      logic [31:0] s;
      logic        co;
      logic        ov;
   } res_t;

   vec_t vecs [14] = '{
      '{16, 32'h7FFF,     32'h0001, 1'b0, 1'b0, 32'h8000,     1'b0, 1'b1},
      '{16, 32'hFFFF,     32'h0001, 1'b1, 1'b0, 32'h0001,     1'b1, 1'b0},
      '{16, 32'h0005,     32'h0007, 1'b0, 1'b1, 32'hFFFE,     1'b0, 1'b0},
      '{16, 32'h8000,     32'h0001, 1'b0, 1'b1, 32'h7FFF,     1'b1, 1'b1},
      '{4,  32'h7,        32'h1,    1'b0, 1'b0, 32'h8,        1'b0, 1'b1},
      '{4,  32'hF,        32'h1,    1'b1, 1'b0, 32'h1,        1'b1, 1'b0},
      '{4,  32'h5,        32'h7,    1'b0, 1'b1, 32'hE,        1'b0, 1'b0},
      '{4,  32'h8,        32'h1,    1'b0, 1'b1, 32'h7,        1'b1, 1'b1},
      '{4,  32'h7,        32'h5,    1'b0, 1'b0, 32'hC,        1'b0, 1'b1},
      '{4,  32'hF,        32'hF,    1'b1, 1'b0, 32'hF,        1'b1, 1'b0},
      '{32, 32'h7FFFFFFF, 32'h1,    1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1},
      '{32, 32'hFFFFFFFF, 32'h1,    1'b1, 1'b0, 32'h00000001, 1'b1, 1'b0},
      '{32, 32'h5,        32'h7,    1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0},
      '{32, 32'h80000000, 32'h1,    1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1}
   };

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        cin;
   logic        sub;
   logic        out_ready;
   logic [31:0] a;
   logic [31:0] b;
   int          sel;
   int          cur_w;
   int          cur_lat;
   int          checks;
   int          failures;
   res_t        sb [$];

   logic        ir16, ov16, c16, f16;
   logic [15:0] s16;
   logic        ir4, ov4, c4, f4;
   logic [3:0]  s4;
   logic        ir32, ov32, c32, f32;
   logic [31:0] s32;

   logic        o_ready, o_valid, o_cout, o_ovf;
   logic [31:0] o_sum;

   always #5 clk = ~clk;

   pipe_adder #(.WIDTH(16), .SLICE(4)) u_w16 (
      .clk(clk), .rst(rst), .in_valid(in_valid && (sel == 0)), .in_ready(ir16),
      .a(a[15:0]), .b(b[15:0]), .cin(cin), .sub(sub),
      .out_valid(ov16), .out_ready(out_ready), .sum(s16), .cout(c16), .ovf(f16)
   );

   pipe_adder #(.WIDTH(4), .SLICE(4)) u_w4 (
      .clk(clk), .rst(rst), .in_valid(in_valid && (sel == 1)), .in_ready(ir4),
      .a(a[3:0]), .b(b[3:0]), .cin(cin), .sub(sub),
      .out_valid(ov4), .out_ready(out_ready), .sum(s4), .cout(c4), .ovf(f4)
   );

   pipe_adder #(.WIDTH(32), .SLICE(8)) u_w32 (
      .clk(clk), .rst(rst), .in_valid(in_valid && (sel == 2)), .in_ready(ir32),
      .a(a), .b(b), .cin(cin), .sub(sub),
      .out_valid(ov32), .out_ready(out_ready), .sum(s32), .cout(c32), .ovf(f32)
   );

   always_comb begin
      o_ready = ir16;
      o_valid = ov16;
      o_sum   = {16'h0, s16};
      o_cout  = c16;
      o_ovf   = f16;
      case (sel)
         1: begin
            o_ready = ir4;  o_valid = ov4;  o_sum = {28'h0, s4};
            o_cout  = c4;   o_ovf   = f4;
         end
         2: begin
            o_ready = ir32; o_valid = ov32; o_sum = s32;
            o_cout  = c32;  o_ovf   = f32;
         end
         default: ;
      endcase
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL [W=%0d] %s: got %h expected %h", cur_w, tag, got, exp);
      end
   endtask

   function automatic res_t model(input int w, input logic [31:0] ma, input logic [31:0] mb,
                                  input logic mcin, input logic msub);
      res_t        r;
      logic [31:0] mask, ea, eb;
      logic [32:0] full;
      mask   = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      ea     = ma & mask;
      eb     = (msub ? ~mb : mb) & mask;
      full   = {1'b0, ea} + {1'b0, eb} + {32'h0, mcin ^ msub};
      r.s    = full[31:0] & mask;
      r.co   = full[w];
      r.ov   = (ea[w-1] == eb[w-1]) && (r.s[w-1] != ea[w-1]);
      return r;
   endfunction

   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      step();
      step();
      rst = 1'b0;
      #1;
      check("rst_out_valid", o_valid, 1'b0);
      check("rst_sum", o_sum, 32'h0);
      check("rst_cout", o_cout, 1'b0);
      check("rst_ovf", o_ovf, 1'b0);
      check("rst_in_ready", o_ready, 1'b1);
   endtask

   task automatic run_vec(input vec_t v);
      a = v.a; b = v.b; cin = v.cin; sub = v.sub;
      in_valid = 1'b1; out_ready = 1'b1;
      #1;
      check("vec_in_ready", o_ready, 1'b1);
      step();
      in_valid = 1'b0;
      for (int i = 1; i <= cur_lat; i++) begin
         if (i > 1) step();
         check("vec_latency", o_valid, (i == cur_lat));
         if (i == cur_lat) begin
            check("vec_sum", o_sum, v.s);
            check("vec_cout", o_cout, v.co);
            check("vec_ovf", o_ovf, v.ov);
         end
      end
      step();
      check("vec_drain", o_valid, 1'b0);
   endtask

   task automatic run_bp();
      logic [31:0] mask;
      logic        prev_stall;
      logic [31:0] prev_sum;
      logic        prev_co, prev_ov;
      int          sent, got;
      res_t        r;
      mask = (cur_w == 32) ? 32'hFFFF_FFFF : ((32'd1 << cur_w) - 32'd1);
      prev_stall = 1'b0; prev_sum = '0; prev_co = 1'b0; prev_ov = 1'b0;
      sent = 0; got = 0;
      sb.delete();
      for (int cyc = 0; cyc < 400 && got < 8; cyc++) begin
         in_valid  = (sent < 8);
         a         = $urandom & mask;
         b         = $urandom & mask;
         cin       = 1'($urandom);
         sub       = 1'($urandom);
         out_ready = 1'($urandom);
         #1;
         if (prev_stall) begin
            check("bp_hold_valid", o_valid, 1'b1);
            check("bp_hold_sum", o_sum, prev_sum);
            check("bp_hold_cout", o_cout, prev_co);
            check("bp_hold_ovf", o_ovf, prev_ov);
         end
         if (o_valid && !out_ready) begin
            check("bp_stall_in_ready", o_ready, 1'b0);
            prev_stall = 1'b1;
            prev_sum   = o_sum;
            prev_co    = o_cout;
            prev_ov    = o_ovf;
         end else begin
            prev_stall = 1'b0;
         end
         if (in_valid && o_ready) begin
            sb.push_back(model(cur_w, a, b, cin, sub));
            sent++;
         end
         if (o_valid && out_ready) begin
            if (sb.size() == 0) begin
               check("bp_unexpected_result", 1'b1, 1'b0);
            end else begin
               r = sb.pop_front();
               check("bp_sum", o_sum, r.s);
               check("bp_cout", o_cout, r.co);
               check("bp_ovf", o_ovf, r.ov);
            end
            got++;
         end
         step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check("bp_result_count", got, 8);
      for (int i = 0; i < 6; i++) begin
         #1;
         check("bp_no_extra", o_valid, 1'b0);
         step();
      end
   endtask

   task automatic run_midreset();
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         a = 32'(i + 1); b = 32'(i + 2); cin = 1'b0; sub = 1'b0;
         in_valid = 1'b1;
         #1;
         check("mr_accept", o_ready, 1'b1);
         step();
         check("mr_no_early_out", o_valid, 1'b0);
      end
      rst = 1'b1;
      a = 32'h1234; b = 32'h0101;
      step();
      rst = 1'b0;
      in_valid = 1'b0;
      check("mr_sum_cleared", o_sum, 32'h0);
      for (int i = 0; i < 6; i++) begin
         a = $urandom; b = $urandom;
         #1;
         check("mr_quiet", o_valid, 1'b0);
         step();
      end
   endtask

   initial begin
      checks = 0; failures = 0; sel = 0; cur_w = 16; cur_lat = 4;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      for (int s = 0; s < 3; s++) begin
         sel = s;
         case (s)
            0:       begin cur_w = 16; cur_lat = 4; end
            1:       begin cur_w = 4;  cur_lat = 1; end
            default: begin cur_w = 32; cur_lat = 4; end
         endcase
         do_reset();
         for (int i = 0; i < 14; i++) begin
            if (vecs[i].w == cur_w) run_vec(vecs[i]);
         end
         run_bp();
         if (cur_lat > 1) run_midreset();
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
